mux_rr_nx1: RTL and testbench
=============================

Name: mux_rr_nx1

Overview:
- Parametrised N-input, W-bit multiplexer that selects among inputs with a round-robin arbiter.
- Uses per-channel valid/ready handshakes and a registered output stage.
- Generalises the team's fixed 8x1 behavioural mux in channel count and data width.
- Adds arbitration, backpressure and one cycle of buffering. Sits between several producer streams and one shared consumer.

Parameters:
- N, 8, number of input channels (N >= 2).
- W, 1, data width per channel in bits (W >= 1).
- SELW, $clog2(N), width of the channel index (derived; not overridden).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset. Synchronous and active-high: sampled only on the rising edge of clk.
- in_data  input  N*W  packed channel data; channel i occupies bits [i*W +: W].
- in_valid  input  N  channel i holds a valid word.
- in_ready  output  N  channel i's word is accepted this cycle (one-hot or zero).
- out_data  output  W  registered selected word.
- out_valid  output  1  out_data/out_sel hold a word.
- out_ready  input  1  consumer accepts the output word this cycle.
- out_sel  output  SELW  index of the channel that supplied out_data.

Behaviour:
- Reset (rst=1 at an edge): out_valid=0, out_data=0, out_sel=0, round-robin pointer ptr=0.
  - in_ready=0 while rst=1.
  - Reset mid-transfer discards the buffered word. No in_ready is asserted in the reset cycle.
- load_ok = !out_valid | out_ready. The output register is empty or is being drained this cycle.
- Arbitration (combinational):
  - grant = the first index g with in_valid[g]=1, searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
  - any_valid = |in_valid.
- in_ready[i] = load_ok & any_valid & (i == grant) & !rst.
  - in_ready may depend combinationally on in_valid and out_ready.
  - No combinational path from in_data to any output.
- Load (load_ok & any_valid):
  - out_data <= in_data[grant], out_sel <= grant, out_valid <= 1.
  - ptr <= grant+1, wrapping from N-1 to 0. Correct for non-power-of-2 N.
- Drain without refill (out_valid & out_ready & !any_valid): out_valid <= 0. out_data and out_sel hold their last values.
- Stall (out_valid & !out_ready): out_data, out_sel, out_valid and ptr are held. All in_ready=0.
- Simultaneous drain and load in one cycle: the new word replaces the old one. Throughput is 1 word/cycle.
- Latency: an input accepted at edge k appears on out_data with out_valid=1 immediately after edge k (1 cycle).
- Fairness: ptr moves only on a grant.
  - With every channel continuously valid and out_ready=1, the grant order is 0,1,...,N-1,0,...
  - No channel waits more than N-1 grants once valid.
- Sources keep in_data[i] stable while in_valid[i]=1 and in_ready[i]=0. The block does not check this.

Optional Feature:
- Macro: MUX_FORCE_SEL_EN.
- Defined: adds ports force_en (input, 1) and force_sel (input, SELW).
  - While force_en=1, grant = force_sel if in_valid[force_sel]=1; otherwise nothing is granted. This gives fixed-select behaviour like the legacy mux.
  - ptr is not updated on forced grants.
  - force_sel >= N grants nothing.
- Undefined: the ports are absent and arbitration is pure round-robin.

Test Plan:
- Reset: assert rst for 2 cycles with all in_valid=1 -> out_valid=0, out_data=0, out_sel=0, in_ready=0 throughout.
- Round-robin: N=8, W=8, in_data[i]=8'hA0+i, all in_valid=1, out_ready=1 -> out_sel sequence 0,1,...,7,0 and out_data A0..A7,A0. Exactly one in_ready bit high per cycle.
- Backpressure: channel 3 only valid with data 8'h5C, out_ready=0 for 4 cycles -> one load, then out_data=8'h5C held, in_ready=0 during the stall. Release out_ready -> next load the following cycle.
- Sparse and wrap: ptr=6, only channels 2 and 7 valid -> channel 7 granted first, then channel 2. After that, ptr=3.
- Non-power-of-2: N=5, all valid -> out_sel 0,1,2,3,4,0; out_sel never equals 5..7.
- MUX_FORCE_SEL_EN: force_en=1, force_sel=4, all valid -> out_sel=4 every cycle. Set force_en=0 -> round-robin resumes from the unchanged ptr.

Source files
------------

// File: rtl/mux_rr_nx1.sv
// N-input, W-bit round-robin multiplexer with valid/ready handshakes and a registered output stage.
// Optional MUX_FORCE_SEL_EN adds force_en/force_sel for fixed-select operation.
module mux_rr_nx1 #(
    parameter int N    = 8,
    parameter int W    = 1,
    parameter int SELW = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N*W-1:0]    in_data,
    input  logic [N-1:0]      in_valid,
    output logic [N-1:0]      in_ready,
    output logic [W-1:0]      out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [SELW-1:0]   out_sel
`ifdef MUX_FORCE_SEL_EN
    ,
    input  logic              force_en,
    input  logic [SELW-1:0]   force_sel
`endif
);

    logic [W-1:0]    chan_data [N];

    logic [SELW-1:0] ptr_reg, ptr_next;
    logic [W-1:0]    out_data_reg, out_data_next;
    logic [SELW-1:0] out_sel_reg, out_sel_next;
    logic            out_valid_reg, out_valid_next;

    logic [SELW-1:0] rr_grant;
    logic            rr_found;
    logic [SELW-1:0] grant;
    logic            grant_valid;
    logic            load_ok;
    logic            load_en;
    logic            ptr_adv;

    // index (base + k) modulo N, valid for any N, not just powers of two
    function automatic logic [SELW-1:0] wrap_add(input logic [SELW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= N) begin
            s = s - N;
        end
        return SELW'(s);
    endfunction

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_chan
            assign chan_data[gi] = in_data[gi*W +: W];
            assign in_ready[gi]  = load_en & (grant == SELW'(gi));
        end
    endgenerate

    // walk from the farthest offset back to ptr so the nearest valid channel wins
    always_comb begin
        rr_grant = '0;
        rr_found = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (in_valid[wrap_add(ptr_reg, k)]) begin
                rr_grant = wrap_add(ptr_reg, k);
                rr_found = 1'b1;
            end
        end
    end

`ifdef MUX_FORCE_SEL_EN
    localparam int VPW = 1 << SELW;
    logic [VPW-1:0] valid_pad;
    assign valid_pad = VPW'(in_valid);

    // a forced index past the last channel grants nothing
    always_comb begin
        grant       = rr_grant;
        grant_valid = rr_found;
        if (force_en) begin
            grant       = force_sel;
            grant_valid = (int'(force_sel) < N) && valid_pad[force_sel];
        end
    end
    assign ptr_adv = load_en & ~force_en;
`else
    assign grant       = rr_grant;
    assign grant_valid = rr_found;
    assign ptr_adv     = load_en;
`endif

    assign load_ok = ~out_valid_reg | out_ready;
    assign load_en = load_ok & grant_valid & ~rst;

    always_comb begin
        ptr_next       = ptr_reg;
        out_data_next  = out_data_reg;
        out_sel_next   = out_sel_reg;
        out_valid_next = out_valid_reg;
        if (load_en) begin
            out_data_next  = chan_data[grant];
            out_sel_next   = grant;
            out_valid_next = 1'b1;
        end else if (out_ready) begin
            out_valid_next = 1'b0;
        end
        if (ptr_adv) begin
            ptr_next = (grant == SELW'(N - 1)) ? '0 : grant + SELW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg       <= '0;
            out_data_reg  <= '0;
            out_sel_reg   <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            ptr_reg       <= ptr_next;
            out_data_reg  <= out_data_next;
            out_sel_reg   <= out_sel_next;
            out_valid_reg <= out_valid_next;
        end
    end

    assign out_data  = out_data_reg;
    assign out_sel   = out_sel_reg;
    assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_mux_rr_nx1.sv
// Bench for mux_rr_nx1: an 8-channel and a 5-channel instance checked every cycle against a
// behavioural model, plus directed reset, round-robin, backpressure, wrap and force scenarios.
module tb_mux_rr_nx1;

    logic        clk = 1'b0;
    logic        rst;
    logic        out_ready;

    logic [63:0] in_data8;
    logic [7:0]  in_valid8;
    logic [7:0]  in_ready8;
    logic [7:0]  out_data8;
    logic        out_valid8;
    logic [2:0]  out_sel8;

    logic [39:0] in_data5;
    logic [4:0]  in_valid5;
    logic [4:0]  in_ready5;
    logic [7:0]  out_data5;
    logic        out_valid5;
    logic [2:0]  out_sel5;

    bit          force_en8 = 1'b0;
    bit          force_en5 = 1'b0;
    logic [2:0]  force_sel8 = '0;
    logic [2:0]  force_sel5 = '0;

    int n_checks = 0;
    int n_errors = 0;
    bit started  = 1'b0;

    int          m_ptr [2];
    bit          m_ov  [2];
    logic [7:0]  m_od  [2];
    int          m_os  [2];

    always #5 clk = ~clk;

    mux_rr_nx1 #(.N(8), .W(8)) u_dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data8),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .out_data  (out_data8),
        .out_valid (out_valid8),
        .out_ready (out_ready),
        .out_sel   (out_sel8)
`ifdef MUX_FORCE_SEL_EN
        ,
        .force_en  (force_en8),
        .force_sel (force_sel8)
`endif
    );

    mux_rr_nx1 #(.N(5), .W(8)) u_dut5 (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data5),
        .in_valid  (in_valid5),
        .in_ready  (in_ready5),
        .out_data  (out_data5),
        .out_valid (out_valid5),
        .out_ready (out_ready),
        .out_sel   (out_sel5)
`ifdef MUX_FORCE_SEL_EN
        ,
        .force_en  (force_en5),
        .force_sel (force_sel5)
`endif
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // first valid channel at or after ptr, circularly; -1 when nothing can be granted
    function automatic int ref_grant(input int n, input int ptr, input logic [7:0] vld,
                                     input bit fen, input int fsel);
        if (fen) begin
            if (fsel < n && vld[fsel]) return fsel;
            return -1;
        end
        for (int k = 0; k < n; k++) begin
            int c;
            c = (ptr + k) % n;
            if (vld[c]) return c;
        end
        return -1;
    endfunction

    // one clock: compare against the model mid-cycle, then advance the model after the edge
    task automatic run_cycle();
        int          n, g, fsel;
        bit          fen, ld;
        logic [7:0]  vld, rdy, dout;
        logic [63:0] dat;
        bit          ov;
        int          os;
        int          nptr [2];
        bit          nov  [2];
        logic [7:0]  nod  [2];
        int          nos  [2];
        @(negedge clk);
        for (int inst = 0; inst < 2; inst++) begin
            if (inst == 0) begin
                n = 8; vld = in_valid8; dat = in_data8; rdy = in_ready8;
                dout = out_data8; ov = out_valid8; os = int'(out_sel8);
                fen = force_en8; fsel = int'(force_sel8);
            end else begin
                n = 5; vld = {3'b000, in_valid5}; dat = {24'h0, in_data5}; rdy = {3'b000, in_ready5};
                dout = out_data5; ov = out_valid5; os = int'(out_sel5);
                fen = force_en5; fsel = int'(force_sel5);
            end
            g  = ref_grant(n, m_ptr[inst], vld, fen, fsel);
            ld = !rst && (!m_ov[inst] || out_ready) && (g >= 0);
            if (started) begin
                check($sformatf("rdy%0d", n), 32'(rdy), ld ? (32'd1 << g) : 32'd0);
                check($sformatf("valid%0d", n), 32'(ov), 32'(m_ov[inst]));
                check($sformatf("data%0d", n), 32'(dout), 32'(m_od[inst]));
                check($sformatf("sel%0d", n), 32'(os), 32'(m_os[inst]));
            end
            nptr[inst] = m_ptr[inst]; nov[inst] = m_ov[inst];
            nod[inst]  = m_od[inst];  nos[inst] = m_os[inst];
            if (rst) begin
                nptr[inst] = 0; nov[inst] = 1'b0; nod[inst] = 8'h00; nos[inst] = 0;
            end else if (ld) begin
                nov[inst] = 1'b1;
                nod[inst] = dat[g*8 +: 8];
                nos[inst] = g;
                if (!fen) nptr[inst] = (g + 1) % n;
            end else if (out_ready) begin
                nov[inst] = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        for (int inst = 0; inst < 2; inst++) begin
            m_ptr[inst] = nptr[inst]; m_ov[inst] = nov[inst];
            m_od[inst]  = nod[inst];  m_os[inst] = nos[inst];
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        run_cycle();
        rst = 1'b0;
    endtask

    task automatic set_ramp_data();
        for (int i = 0; i < 8; i++) in_data8[i*8 +: 8] = 8'hA0 + 8'(i);
        for (int i = 0; i < 5; i++) in_data5[i*8 +: 8] = 8'hB0 + 8'(i);
    endtask

    initial begin
        rst = 1'b1; out_ready = 1'b1;
        in_valid8 = '1; in_valid5 = '1;
        in_data8 = '0; in_data5 = '0;
        set_ramp_data();

        // reset held two cycles with every channel valid
        run_cycle();
        started = 1'b1;
        run_cycle();
        run_cycle();
        check("rst_valid8", 32'(out_valid8), 32'd0);
        check("rst_data8", 32'(out_data8), 32'd0);
        check("rst_sel8", 32'(out_sel8), 32'd0);
        check("rst_rdy8", 32'(in_ready8), 32'd0);
        check("rst_rdy5", 32'(in_ready5), 32'd0);

        // full round robin on both instances
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            run_cycle();
            check("rr_sel8", 32'(out_sel8), 32'(i % 8));
            check("rr_data8", 32'(out_data8), 32'(8'hA0 + 8'(i % 8)));
            check("rr_sel5", 32'(out_sel5), 32'(i % 5));
            check("rr_data5", 32'(out_data5), 32'(8'hB0 + 8'(i % 5)));
        end

        // backpressure: channel 3 alone, consumer stalled
        do_reset();
        in_valid8 = 8'h08; in_valid5 = 5'h08;
        in_data8[3*8 +: 8] = 8'h5C;
        out_ready = 1'b0;
        run_cycle();
        for (int i = 0; i < 4; i++) begin
            run_cycle();
            check("bp_valid8", 32'(out_valid8), 32'd1);
            check("bp_data8", 32'(out_data8), 32'h5C);
            check("bp_rdy8", 32'(in_ready8), 32'd0);
        end
        out_ready = 1'b1;
        #2;
        check("bp_release_rdy8", 32'(in_ready8), 32'h08);
        run_cycle();
        check("bp_release_sel8", 32'(out_sel8), 32'd3);

        // sparse wrap: ptr to 6, then only channels 2 and 7
        set_ramp_data();
        do_reset();
        in_valid8 = '1; in_valid5 = '1;
        for (int i = 0; i < 6; i++) run_cycle();
        in_valid8 = 8'h84;
        run_cycle();
        check("wrap_first8", 32'(out_sel8), 32'd7);
        run_cycle();
        check("wrap_second8", 32'(out_sel8), 32'd2);
        in_valid8 = '1;
        run_cycle();
        check("wrap_ptr8", 32'(out_sel8), 32'd3);

`ifdef MUX_FORCE_SEL_EN
        do_reset();
        in_valid8 = '1; in_valid5 = '1;
        force_en8 = 1'b1; force_sel8 = 3'd4;
        force_en5 = 1'b1; force_sel5 = 3'd6;
        for (int i = 0; i < 4; i++) begin
            run_cycle();
            check("force_sel8", 32'(out_sel8), 32'd4);
            check("force_oob_valid5", 32'(out_valid5), 32'd0);
        end
        force_en8 = 1'b0; force_en5 = 1'b0;
        run_cycle();
        check("force_resume8", 32'(out_sel8), 32'd0);
`endif

        // randomized traffic
        for (int i = 0; i < 500; i++) begin
            rst       = ($urandom_range(0, 99) < 2);
            out_ready = ($urandom_range(0, 99) < 70);
            in_valid8 = 8'($urandom);
            in_valid5 = 5'($urandom);
            in_data8  = {$urandom, $urandom};
            in_data5  = 40'({$urandom, $urandom});
`ifdef MUX_FORCE_SEL_EN
            force_en8  = ($urandom_range(0, 99) < 15);
            force_en5  = ($urandom_range(0, 99) < 15);
            force_sel8 = 3'($urandom_range(0, 7));
            force_sel5 = 3'($urandom_range(0, 7));
`endif
            run_cycle();
            check("rand_sel5_range", 32'(out_sel5 < 3'd5), 32'd1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
